mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_lsu.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : MEM pipeline stage between EX and WB. Forwards ALU results
//               and executes loads/stores over a valid/ready data-memory
//               port. Loads get lane extraction plus sign/zero extension;
//               stores get byte strobes and lane-shifted data. Both pipeline
//               boundaries are valid/ready, so the stage stalls cleanly on
//               memory or write-back back-pressure.
// Ports       : clk/rst            - clock, synchronous active-high reset
//               in_*, wd_i, wreg_i, wdata_i, mem_op_i, store_data_i
//                                  - op from EX (valid/ready)
//               dmem_req_*, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata
//                                  - data-memory request channel
//               dmem_rsp_valid, dmem_rdata - data-memory load response
//               out_*, wd_o, wreg_o, wdata_o, misalign_o
//                                  - result to WB (valid/ready)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] wd_i,
    input  logic              wreg_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [3:0]        mem_op_i,
    input  logic [XLEN-1:0]   store_data_i,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN/8-1:0] dmem_wstrb,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] wd_o,
    output logic              wreg_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              misalign_o
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    localparam logic [3:0] c_op_lb  = 4'd1;
    localparam logic [3:0] c_op_lh  = 4'd2;
    localparam logic [3:0] c_op_lw  = 4'd3;
    localparam logic [3:0] c_op_ld  = 4'd4;
    localparam logic [3:0] c_op_lbu = 4'd5;
    localparam logic [3:0] c_op_lhu = 4'd6;
    localparam logic [3:0] c_op_lwu = 4'd7;
    localparam logic [3:0] c_op_sb  = 4'd8;
    localparam logic [3:0] c_op_sh  = 4'd9;
    localparam logic [3:0] c_op_sw  = 4'd10;
    localparam logic [3:0] c_op_sd  = 4'd11;

    // A 32-bit datapath cannot service doubleword or LWU accesses at all.
    localparam logic c_rv32 = (XLEN == 32) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;

    logic [3:0]         r_op;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_store;

    logic               w_is_load;
    logic               w_is_store;
    logic               w_is_h;
    logic               w_is_w;
    logic               w_is_d;
    logic               w_mis;

    logic [OFF_W-1:0]   w_off;
    logic [OFF_W+2:0]   w_shamt;
    logic [XLEN-1:0]    w_lane;
    logic [XLEN-1:0]    w_load;
    logic [STRB_W-1:0]  w_strb;
    logic               w_req;

    // ------------------------------------------------------------------
    // Decode of the incoming op (used only in the acceptance cycle)
    // ------------------------------------------------------------------
    always_comb begin
        w_is_h = 1'b0;
        w_is_w = 1'b0;
        w_is_d = 1'b0;
        case (mem_op_i)
            c_op_lh, c_op_lhu, c_op_sh: w_is_h = 1'b1;
            c_op_lw, c_op_lwu, c_op_sw: w_is_w = 1'b1;
            c_op_ld, c_op_sd:           w_is_d = 1'b1;
            default: ;
        endcase
        w_is_load  = (mem_op_i >= c_op_lb) && (mem_op_i <= c_op_lwu);
        w_is_store = (mem_op_i >= c_op_sb) && (mem_op_i <= c_op_sd);
        w_mis = (w_is_h & wdata_i[0])
              | (w_is_w & (|wdata_i[1:0]))
              | (w_is_d & (|wdata_i[2:0]))
              | (c_rv32 & ((mem_op_i == c_op_ld) | (mem_op_i == c_op_lwu)
                           | (mem_op_i == c_op_sd)));
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_REQ: begin
                // Stores (op codes 8..11 all have bit 3 set) finish here.
                if (dmem_req_ready) begin
                    w_next = r_op[3] ? S_OUT : S_RESP;
                end
            end
            S_RESP: begin
                if (dmem_rsp_valid) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                in_ready = out_ready;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        w_accept = in_valid & in_ready;
        // Accept overrides the OUT->IDLE exit so back-to-back ops have no bubble.
        if (w_accept) begin
            w_next = ((w_is_load | w_is_store) & ~w_mis) ? S_REQ : S_OUT;
        end
    end

    // ------------------------------------------------------------------
    // Memory-side datapath, all derived from captured registers so the
    // request stays stable for as long as REQ lasts
    // ------------------------------------------------------------------
    assign w_off   = r_addr[OFF_W-1:0];
    assign w_shamt = {w_off, 3'b000};
    assign w_lane  = dmem_rdata >> w_shamt;
    assign w_req   = (r_state == S_REQ);

    always_comb begin
        w_load = w_lane;
        case (r_op)
            c_op_lb:  w_load = XLEN'($signed(w_lane[7:0]));
            c_op_lh:  w_load = XLEN'($signed(w_lane[15:0]));
            c_op_lw:  w_load = XLEN'($signed(w_lane[31:0]));
            c_op_lbu: w_load = XLEN'(w_lane[7:0]);
            c_op_lhu: w_load = XLEN'(w_lane[15:0]);
            c_op_lwu: w_load = XLEN'(w_lane[31:0]);
            default:  w_load = w_lane;
        endcase
    end

    always_comb begin
        w_strb = '0;
        case (r_op)
            c_op_sb: w_strb = STRB_W'(1)  << w_off;
            c_op_sh: w_strb = STRB_W'(3)  << w_off;
            c_op_sw: w_strb = STRB_W'(15) << w_off;
            c_op_sd: w_strb = '1;
            default: w_strb = '0;
        endcase
    end

    assign dmem_req_valid = w_req;
    assign dmem_we        = w_req & r_op[3];
    assign dmem_addr      = w_req ? {r_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign dmem_wstrb     = w_req ? w_strb : '0;
    assign dmem_wdata     = w_req ? (r_store << w_shamt) : '0;
    assign out_valid      = (r_state == S_OUT);

    // ------------------------------------------------------------------
    // Captured op fields and WB-side result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_addr     <= '0;
            r_store    <= '0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            misalign_o <= 1'b0;
        end else if (w_accept) begin
            r_op       <= mem_op_i;
            r_addr     <= wdata_i;
            r_store    <= store_data_i;
            wd_o       <= wd_i;
            // Stores and faulting accesses never write the register file.
            wreg_o     <= wreg_i & ~w_is_store & ~w_mis;
            wdata_o    <= wdata_i;
            misalign_o <= w_mis;
        end else if ((r_state == S_RESP) && dmem_rsp_valid) begin
            wdata_o    <= w_load;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu (XLEN=64) with a
//               byte-arithmetic reference model of loads, stores and
//               alignment faults.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [63:0] wdata_i;
    logic [3:0]  mem_op_i;
    logic [63:0] store_data_i;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [7:0]  dmem_wstrb;
    logic [63:0] dmem_wdata;
    logic        dmem_rsp_valid;
    logic [63:0] dmem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [63:0] wdata_o;
    logic        misalign_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations collected by run_op
    logic        obs_got_req, obs_stable, obs_we, obs_got_out, obs_wreg, obs_mis;
    logic [63:0] obs_addr, obs_wdata, obs_res;
    logic [7:0]  obs_strb;
    logic [4:0]  obs_wd;

    mem_stage_lsu #(.XLEN(64), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_op_i(mem_op_i), .store_data_i(store_data_i),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            4'd1, 4'd5, 4'd8:  return 1;
            4'd2, 4'd6, 4'd9:  return 2;
            4'd3, 4'd7, 4'd10: return 4;
            4'd4, 4'd11:       return 8;
            default:           return 0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd7);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd11);
    endfunction

    function automatic logic model_mis(input logic [3:0] op, input logic [63:0] addr);
        int n = op_bytes(op);
        if (n <= 1) return 1'b0;
        return (int'(addr[2:0]) % n) != 0;
    endfunction

    function automatic logic [63:0] model_load(input logic [3:0] op, input logic [63:0] addr,
                                               input logic [63:0] rdata);
        int          n    = op_bytes(op);
        logic [63:0] lane = rdata >> (8 * int'(addr[2:0]));
        logic [63:0] v;
        if (n == 8) return lane;
        v = lane % (64'd1 << (8 * n));
        if ((op <= 4'd3) && (v >= (64'd1 << (8 * n - 1))))
            v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [7:0] model_strb(input logic [3:0] op, input logic [63:0] addr);
        int n = op_bytes(op);
        if (!op_is_store(op)) return 8'h00;
        return 8'(((1 << n) - 1) << int'(addr[2:0]));
    endfunction

    // ---------------- single-op driver (collects observations only) ----------------
    task automatic run_op(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [63:0] rdata, input logic [4:0] wd,
                          input int req_delay, input int rsp_delay);
        int rcnt = 0;
        obs_got_req = 1'b0; obs_stable = 1'b1; obs_got_out = 1'b0;
        obs_addr = '0; obs_we = 1'b0; obs_strb = '0; obs_wdata = '0;
        obs_wd = '0; obs_wreg = 1'b0; obs_res = '0; obs_mis = 1'b0;
        in_valid = 1'b1; mem_op_i = op; wdata_i = addr; store_data_i = sdata;
        wd_i = wd; wreg_i = 1'b1;
        tick();
        in_valid = 1'b0; mem_op_i = 4'd0; wdata_i = {$urandom, $urandom};
        store_data_i = {$urandom, $urandom};
        for (int cyc = 0; cyc < 40 && !obs_got_out; cyc++) begin
            if (out_valid) begin
                obs_got_out = 1'b1; obs_wd = wd_o; obs_wreg = wreg_o;
                obs_res = wdata_o; obs_mis = misalign_o;
                tick();
            end else if (dmem_req_valid) begin
                if (!obs_got_req) begin
                    obs_got_req = 1'b1; obs_addr = dmem_addr; obs_we = dmem_we;
                    obs_strb = dmem_wstrb; obs_wdata = dmem_wdata;
                end else if (dmem_addr !== obs_addr || dmem_we !== obs_we ||
                             dmem_wstrb !== obs_strb || dmem_wdata !== obs_wdata) begin
                    obs_stable = 1'b0;
                end
                if (rcnt >= req_delay) begin
                    dmem_req_ready = 1'b1;
                    tick();
                    dmem_req_ready = 1'b0;
                    if (op_is_load(op)) begin
                        repeat (rsp_delay) tick();
                        dmem_rsp_valid = 1'b1; dmem_rdata = rdata;
                        tick();
                        dmem_rsp_valid = 1'b0; dmem_rdata = {$urandom, $urandom};
                    end
                end else begin
                    rcnt++;
                    tick();
                end
            end else begin
                tick();
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic quiet = 1'b1;
        rst = 1'b1;
        tick(); tick();
        n_tests++;
        if (out_valid !== 1'b0 || dmem_req_valid !== 1'b0 || in_ready !== 1'b1 ||
            wd_o !== 5'd0 || wreg_o !== 1'b0 || wdata_o !== 64'd0 || misalign_o !== 1'b0 ||
            dmem_we !== 1'b0 || dmem_addr !== 64'd0 || dmem_wstrb !== 8'd0 || dmem_wdata !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b req_valid=%b in_ready=%b wdata_o=%h addr=%h strb=%h, required 0/0/1 and zeros",
                     out_valid, dmem_req_valid, in_ready, wdata_o, dmem_addr, dmem_wstrb);
        end
        rst = 1'b0;
        // Park an LD in RESP, then reset.
        in_valid = 1'b1; mem_op_i = 4'd4; wdata_i = 64'h3000; wd_i = 5'd3; wreg_i = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (dmem_req_valid !== 1'b1 || dmem_addr !== 64'h3000 || dmem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_request: req_valid=%b addr=%h we=%b, required 1/3000/0",
                     dmem_req_valid, dmem_addr, dmem_we);
        end
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || dmem_req_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_resp: out_valid=%b req_valid=%b in_ready=%b, required 0/0/1",
                     out_valid, dmem_req_valid, in_ready);
        end
        dmem_rsp_valid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        dmem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b0 || wdata_o !== 64'd0) quiet = 1'b0;
            tick();
        end
        n_tests++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL late_response: produced output (out_valid=%b wdata_o=%h), required none",
                     out_valid, wdata_o);
        end
    endtask

    task automatic test_none_stall();
        logic held = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1; mem_op_i = 4'd0; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 64'h1234;
        tick();
        // Offer a different op while stalled; it must not be taken.
        wd_i = 5'd9; wdata_i = 64'h9999; wreg_i = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || wd_o !== 5'd5 || wreg_o !== 1'b1 || wdata_o !== 64'h1234 ||
            in_ready !== 1'b0 || misalign_o !== 1'b0) begin
            n_fail++;
            $display("FAIL none_latency: valid=%b wd=%0d wreg=%b wdata=%h in_ready=%b, required 1/5/1/1234/0",
                     out_valid, wd_o, wreg_o, wdata_o, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid !== 1'b1 || wd_o !== 5'd5 || wreg_o !== 1'b1 ||
                wdata_o !== 64'h1234 || in_ready !== 1'b0) held = 1'b0;
        end
        n_tests++;
        if (held !== 1'b1) begin
            n_fail++;
            $display("FAIL none_hold: valid=%b wd=%0d wdata=%h, required held 1/5/1234", out_valid, wd_o, wdata_o);
        end
        out_ready = 1'b1; wd_i = 5'd7; wreg_i = 1'b0; wdata_i = 64'h5678;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_passthru: in_ready=%b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || wd_o !== 5'd7 || wreg_o !== 1'b0 || wdata_o !== 64'h5678) begin
            n_fail++;
            $display("FAIL none_no_bubble: valid=%b wd=%0d wreg=%b wdata=%h, required 1/7/0/5678",
                     out_valid, wd_o, wreg_o, wdata_o);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL out_to_idle: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_load_ext();
        run_op(4'd1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 5'd4, 0, 1);
        n_tests++;
        if (!obs_got_out || obs_res !== 64'hFFFF_FFFF_FFFF_FF80 || obs_wreg !== 1'b1 ||
            obs_addr !== 64'h1000 || obs_strb !== 8'h00 || obs_we !== 1'b0 || obs_mis !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_sign: got_out=%b res=%h wreg=%b addr=%h strb=%h, required 1/ffffffffffffff80/1/1000/00",
                     obs_got_out, obs_res, obs_wreg, obs_addr, obs_strb);
        end
        run_op(4'd5, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 5'd4, 1, 2);
        n_tests++;
        if (!obs_got_out || obs_res !== 64'h80 || obs_wreg !== 1'b1) begin
            n_fail++;
            $display("FAIL lbu_zero: got_out=%b res=%h wreg=%b, required 1/80/1", obs_got_out, obs_res, obs_wreg);
        end
    endtask

    task automatic test_store();
        run_op(4'd9, 64'h2006, 64'hABCD, 64'h0, 5'd6, 2, 0);
        n_tests++;
        if (!obs_got_req || obs_addr !== 64'h2000 || obs_strb !== 8'hC0 ||
            obs_wdata[63:48] !== 16'hABCD || obs_we !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_request: req=%b addr=%h strb=%h wdata=%h we=%b, required 1/2000/c0/abcd..../1",
                     obs_got_req, obs_addr, obs_strb, obs_wdata, obs_we);
        end
        n_tests++;
        if (obs_stable !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_stable: request changed while waiting (stable=%b), required 1", obs_stable);
        end
        n_tests++;
        if (!obs_got_out || obs_wreg !== 1'b0 || obs_mis !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_done: got_out=%b wreg=%b mis=%b, required 1/0/0", obs_got_out, obs_wreg, obs_mis);
        end
    endtask

    task automatic test_misalign();
        logic [63:0] rd = {$urandom, $urandom};
        run_op(4'd3, 64'h1002, 64'h0, 64'h0, 5'd8, 0, 0);
        n_tests++;
        if (obs_got_req !== 1'b0 || !obs_got_out || obs_mis !== 1'b1 || obs_wreg !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_misalign: req=%b got_out=%b mis=%b wreg=%b, required 0/1/1/0",
                     obs_got_req, obs_got_out, obs_mis, obs_wreg);
        end
        run_op(4'd3, 64'h1004, 64'h0, rd, 5'd8, 0, 0);
        n_tests++;
        if (!obs_got_req || !obs_got_out || obs_mis !== 1'b0 ||
            obs_res !== model_load(4'd3, 64'h1004, rd)) begin
            n_fail++;
            $display("FAIL misalign_clear: req=%b mis=%b res=%h, required 1/0/%h",
                     obs_got_req, obs_mis, obs_res, model_load(4'd3, 64'h1004, rd));
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        int          bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; mem_op_i = 4'd0; wd_i = 5'(i); wreg_i = 1'b1;
            wdata_i = {$urandom, $urandom};
            exp_q.push_back(wdata_i);
            tick();
            if (out_valid !== 1'b1 || wd_o !== 5'(i) || wdata_o !== exp_q[i]) bad++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL back_to_back: %0d of 10 cycles wrong or missing, required 0", bad);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [3:0]  op    = 4'($urandom_range(0, 11));
            logic [63:0] addr  = {32'h0, $urandom};
            logic [63:0] sdata = {$urandom, $urandom};
            logic [63:0] rdata = {$urandom, $urandom};
            logic [4:0]  wd    = 5'($urandom);
            logic        ok    = 1'b1;
            logic [7:0]  es;
            int          off;
            run_op(op, addr, sdata, rdata, wd, $urandom_range(0, 3), $urandom_range(0, 3));
            es  = model_strb(op, addr);
            off = int'(addr[2:0]);
            if (!obs_got_out || obs_wd !== wd) ok = 1'b0;
            if (op_bytes(op) == 0) begin
                if (obs_got_req || obs_res !== addr || obs_wreg !== 1'b1 || obs_mis) ok = 1'b0;
            end else if (model_mis(op, addr)) begin
                if (obs_got_req || obs_wreg !== 1'b0 || obs_mis !== 1'b1) ok = 1'b0;
            end else begin
                if (!obs_got_req || !obs_stable || obs_mis !== 1'b0 ||
                    obs_addr !== {addr[63:3], 3'b000} || obs_strb !== es) ok = 1'b0;
                if (op_is_load(op)) begin
                    if (obs_we !== 1'b0 || obs_wreg !== 1'b1 ||
                        obs_res !== model_load(op, addr, rdata)) ok = 1'b0;
                end else begin
                    if (obs_we !== 1'b1 || obs_wreg !== 1'b0) ok = 1'b0;
                    for (int b = 0; b < 8; b++)
                        if (es[b] && obs_wdata[8*b +: 8] !== sdata[8*(b-off) +: 8]) ok = 1'b0;
                end
            end
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL random_op[%0d]: op=%0d addr=%h got req=%b addr=%h strb=%h wdata=%h res=%h wreg=%b mis=%b, required strb=%h res=%h mis=%b",
                         k, op, addr, obs_got_req, obs_addr, obs_strb, obs_wdata, obs_res, obs_wreg,
                         obs_mis, es, model_load(op, addr, rdata), model_mis(op, addr));
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
        mem_op_i = '0; store_data_i = '0; dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0; dmem_rdata = '0; out_ready = 1'b1;
        test_reset();
        test_none_stall();
        test_load_ext();
        test_store();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
